param_bus_arbiter: RTL and testbench
====================================

PARAM_BUS_ARBITER -- requirements
Module: param_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 7, parameter-register address width.
REQ-002 The block SHALL have parameter SEL_W, default 5, one-hot bank select width {com,m2,m1,osc,env}.
REQ-003 The block SHALL have parameter RD_LAT, default 2, range 1..7, reg_clk cycles from bus_read strobe to valid bus_rdata.
REQ-004 The block SHALL have port reg_clk, input, 1 bit, the only clock.
REQ-005 The block SHALL have port reset_reg, input, 1 bit; reset is asynchronous and active-high.
REQ-006 The block SHALL have the CPU requester ports cpu_req in 1, cpu_wr in 1 (1=write, 0=read), cpu_addr in ADDR_W, cpu_sel in SEL_W, cpu_wdata in 8, cpu_ack out 1, cpu_rdata out 8.
REQ-007 The block SHALL have the SysEx requester ports syx_req in 1, syx_wr in 1, syx_addr in ADDR_W, syx_sel in SEL_W, syx_wdata in 8, syx_ack out 1, syx_rdata out 8.
REQ-008 The block SHALL have the shared bus ports bus_addr out ADDR_W, bus_sel out SEL_W, bus_write out 1, bus_read out 1, bus_wdata out 8, bus_rdata in 8.
REQ-009 The block SHALL have status ports bus_owner out 1 (0=CPU, 1=SysEx) and busy out 1 (FSM not IDLE).

Function
REQ-010 The FSM SHALL have states IDLE, SETUP, STROBE, WAIT and ACK, all registered on reg_clk.
REQ-011 In IDLE with any req high, the FSM SHALL latch the winner's wr/addr/sel/wdata, set bus_owner, and go to SETUP.
REQ-012 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; a single request wins outright.
REQ-013 In SETUP (1 cycle), bus_addr, bus_sel and bus_wdata SHALL be driven from the latched values with both strobes low; then go to STROBE.
REQ-014 In STROBE (1 cycle), bus_write=1 if latched wr=1, else bus_read=1; write goes to ACK, read goes to WAIT.
REQ-015 WAIT SHALL last RD_LAT-1 cycles (a down-counter), then go to ACK; RD_LAT=1 SHALL skip WAIT.
REQ-016 On the read path, bus_rdata SHALL be sampled on the edge entering ACK, i.e. exactly RD_LAT edges after the STROBE edge, into the owner's rdata register.
REQ-017 ACK SHALL last 1 cycle with the owner's ack=1; the next state SHALL be IDLE.
REQ-018 Write latency SHALL be: ack high in the 3rd cycle after the IDLE cycle sampling req. Read latency SHALL be 2+RD_LAT cycles.
REQ-019 bus_addr/bus_sel/bus_wdata SHALL hold their values from SETUP through ACK and return to 0 in IDLE; bus_sel SHALL be all-zero outside SETUP..ACK.
REQ-020 Only one of bus_write/bus_read SHALL ever be high, for exactly one cycle per grant.
REQ-021 Requests SHALL NOT be sampled outside IDLE; a req arriving mid-transaction waits and is not lost while held.
REQ-022 A requester SHALL hold req and its fields stable until its ack; req still high in the IDLE cycle after ack SHALL count as a new request.
REQ-023 A requester's rdata SHALL keep its last captured value until that requester's next read completes; write completions SHALL NOT alter rdata.
REQ-024 req dropped before ack SHALL NOT abort the transaction; it completes and ack still pulses.

Reset
REQ-025 Asserting reset_reg at any time, including mid-transaction, SHALL immediately force IDLE and zero all outputs and rdata registers, with no strobe emitted.
REQ-026 The round-robin pointer SHALL reset to "SysEx granted last", so the CPU wins the first tie.
REQ-027 After reset deassertion, the first req SHALL be sampled on the first rising edge of reg_clk with reset_reg low.

Verification
REQ-028 CPU write addr=0x12, sel=00010, wdata=0xA5 -> bus_write pulse in cycle 2 with those values; cpu_ack in cycle 3; syx_ack stays 0.
REQ-029 SysEx read addr=0x05, RD_LAT=2, with the model returning 0x3C two cycles after bus_read -> syx_rdata=0x3C and syx_ack in cycle 4.
REQ-030 Both requesters write continuously after reset -> grants alternate CPU, SysEx, CPU, ...; each ack is 1 cycle, and bus_write never fires twice within 4 cycles.
REQ-031 syx_req rises during a CPU STROBE -> the CPU completes; SysEx is granted in the IDLE cycle right after cpu_ack.
REQ-032 reset_reg pulses during WAIT of a CPU read -> all outputs 0 at once, no ack, cpu_rdata=0; a later CPU read completes normally.
REQ-033 RD_LAT=1 read -> WAIT skipped; ack in cycle 3; data sampled one edge after bus_read.

Source files
------------

// File: rtl/param_bus_arbiter.sv
// Two-master (CPU / SysEx) arbiter onto a shared parameter-register bus.
// Round-robin grant, fixed SETUP/STROBE/ACK handshake, reads wait RD_LAT cycles for data.
module param_bus_arbiter #(
    parameter int ADDR_W = 7,
    parameter int SEL_W  = 5,
    parameter int RD_LAT = 2
) (
    input  logic              reg_clk,
    input  logic              reset_reg,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [SEL_W-1:0]  cpu_sel,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    input  logic              syx_req,
    input  logic              syx_wr,
    input  logic [ADDR_W-1:0] syx_addr,
    input  logic [SEL_W-1:0]  syx_sel,
    input  logic [7:0]        syx_wdata,
    output logic              syx_ack,
    output logic [7:0]        syx_rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [SEL_W-1:0]  bus_sel,
    output logic              bus_write,
    output logic              bus_read,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    output logic              bus_owner,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT, ACK} state_t;

    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t            state, state_nx;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  sel_q;
    logic [7:0]        wdata_q;
    logic              owner_q;
    logic              last_q;     // 1 = SysEx was granted last
    logic [2:0]        cnt_q;
    logic              grant_syx;
    logic              capture;

    // SysEx wins when alone, or on a tie when the CPU had the previous grant.
    assign grant_syx = syx_req && (!cpu_req || !last_q);
    assign capture   = (state_nx == ACK) && !wr_q;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cpu_req || syx_req) state_nx = SETUP;
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = (wr_q || RD_LAT == 1) ? ACK : WAIT;
            WAIT:    if (cnt_q == 3'd0) state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge reg_clk or posedge reset_reg) begin
        if (reset_reg) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            cpu_rdata <= '0;
            syx_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (cpu_req || syx_req)) begin
                owner_q <= grant_syx;
                last_q  <= grant_syx;
                wr_q    <= grant_syx ? syx_wr    : cpu_wr;
                addr_q  <= grant_syx ? syx_addr  : cpu_addr;
                sel_q   <= grant_syx ? syx_sel   : cpu_sel;
                wdata_q <= grant_syx ? syx_wdata : cpu_wdata;
            end
            if (state_nx == WAIT && state == STROBE)
                cnt_q <= WAIT_INIT;
            else if (state == WAIT && cnt_q != 3'd0)
                cnt_q <= cnt_q - 3'd1;
            if (capture) begin
                if (owner_q) syx_rdata <= bus_rdata;
                else         cpu_rdata <= bus_rdata;
            end
        end
    end

    // Bus fields are decoded from state so reset clears them in the same instant.
    always_comb begin
        bus_addr  = (state != IDLE) ? addr_q  : '0;
        bus_sel   = (state != IDLE) ? sel_q   : '0;
        bus_wdata = (state != IDLE) ? wdata_q : '0;
        bus_write = (state == STROBE) &&  wr_q;
        bus_read  = (state == STROBE) && !wr_q;
        cpu_ack   = (state == ACK) && !owner_q;
        syx_ack   = (state == ACK) &&  owner_q;
        bus_owner = owner_q;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_param_bus_arbiter.sv
// Directed bench for param_bus_arbiter: RD_LAT=2 main instance plus an RD_LAT=1 instance.
module tb_param_bus_arbiter;

    logic       reg_clk = 1'b0;
    logic       reset_reg;
    logic       cpu_req, cpu_wr, syx_req, syx_wr;
    logic [6:0] cpu_addr, syx_addr, bus_addr;
    logic [4:0] cpu_sel, syx_sel, bus_sel;
    logic [7:0] cpu_wdata, syx_wdata, cpu_rdata, syx_rdata, bus_wdata, bus_rdata;
    logic       cpu_ack, syx_ack, bus_write, bus_read, bus_owner, busy;
    logic [7:0] rd_val;
    logic       rd_d;

    logic       c1_req;
    logic [6:0] c1_addr, b1_addr;
    logic [4:0] b1_sel;
    logic [7:0] c1_rdata, s1_rdata, b1_wdata, b1_rdata;
    logic       c1_ack, s1_ack, b1_write, b1_read, b1_owner, b1_busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 reg_clk = ~reg_clk;

    // Bus slave model: data valid in the cycle RD_LAT-1 after the bus_read cycle.
    always @(posedge reg_clk) rd_d <= bus_read;
    assign bus_rdata = rd_d ? rd_val : 8'hEE;
    assign b1_rdata  = b1_read ? 8'hC3 : 8'hEE;

    param_bus_arbiter #(.ADDR_W(7), .SEL_W(5), .RD_LAT(2)) dut (
        .reg_clk(reg_clk), .reset_reg(reset_reg),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_sel(cpu_sel),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .syx_req(syx_req), .syx_wr(syx_wr), .syx_addr(syx_addr), .syx_sel(syx_sel),
        .syx_wdata(syx_wdata), .syx_ack(syx_ack), .syx_rdata(syx_rdata),
        .bus_addr(bus_addr), .bus_sel(bus_sel), .bus_write(bus_write), .bus_read(bus_read),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_owner(bus_owner), .busy(busy)
    );

    param_bus_arbiter #(.ADDR_W(7), .SEL_W(5), .RD_LAT(1)) dut1 (
        .reg_clk(reg_clk), .reset_reg(reset_reg),
        .cpu_req(c1_req), .cpu_wr(1'b0), .cpu_addr(c1_addr), .cpu_sel(5'b00100),
        .cpu_wdata(8'h00), .cpu_ack(c1_ack), .cpu_rdata(c1_rdata),
        .syx_req(1'b0), .syx_wr(1'b0), .syx_addr(7'h00), .syx_sel(5'b00000),
        .syx_wdata(8'h00), .syx_ack(s1_ack), .syx_rdata(s1_rdata),
        .bus_addr(b1_addr), .bus_sel(b1_sel), .bus_write(b1_write), .bus_read(b1_read),
        .bus_wdata(b1_wdata), .bus_rdata(b1_rdata), .bus_owner(b1_owner), .busy(b1_busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge reg_clk);
    endtask

    initial begin
        int nstb, nca, nsa, last_i;
        reset_reg = 1'b1;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_sel = 0; cpu_wdata = 0;
        syx_req = 0; syx_wr = 0; syx_addr = 0; syx_sel = 0; syx_wdata = 0;
        c1_req = 0; c1_addr = 0; rd_val = 8'h00;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_sel", bus_sel, 0);
        chk("rst_owner", bus_owner, 0);
        chk("rst_rdata", cpu_rdata, 0);

        // CPU write, req presented together with reset release
        reset_reg = 0;
        cpu_req = 1; cpu_wr = 1; cpu_addr = 7'h12; cpu_sel = 5'b00010; cpu_wdata = 8'hA5;
        step();
        chk("w_c1_busy", busy, 1);
        chk("w_c1_sel", bus_sel, 5'b00010);
        chk("w_c1_strobe", {bus_write, bus_read}, 2'b00);
        step();
        chk("w_c2_write", bus_write, 1);
        chk("w_c2_read", bus_read, 0);
        chk("w_c2_addr", bus_addr, 7'h12);
        chk("w_c2_wdata", bus_wdata, 8'hA5);
        chk("w_c2_ack", cpu_ack, 0);
        step();
        chk("w_c3_ack", cpu_ack, 1);
        chk("w_c3_syxack", syx_ack, 0);
        chk("w_c3_write", bus_write, 0);
        cpu_req = 0;
        step();
        chk("w_c4_busy", busy, 0);
        chk("w_c4_sel", bus_sel, 0);
        chk("w_c4_addr", bus_addr, 0);
        chk("w_c4_ack", cpu_ack, 0);

        // SysEx read, RD_LAT=2
        rd_val = 8'h3C;
        syx_req = 1; syx_wr = 0; syx_addr = 7'h05; syx_sel = 5'b00001;
        step();
        step();
        chk("r_c2_read", bus_read, 1);
        chk("r_c2_addr", bus_addr, 7'h05);
        chk("r_c2_owner", bus_owner, 1);
        step();
        chk("r_c3_read", bus_read, 0);
        chk("r_c3_ack", syx_ack, 0);
        step();
        chk("r_c4_ack", syx_ack, 1);
        chk("r_c4_rdata", syx_rdata, 8'h3C);
        chk("r_c4_cpurdata", cpu_rdata, 0);
        syx_req = 0;
        step();

        // CPU write with req dropped right after grant still completes; rdata untouched
        cpu_req = 1; cpu_wr = 1; cpu_addr = 7'h01; cpu_wdata = 8'h5A;
        step();
        cpu_req = 0;
        step();
        chk("drop_write", bus_write, 1);
        step();
        chk("drop_ack", cpu_ack, 1);
        chk("drop_syxrdata", syx_rdata, 8'h3C);
        step();

        // Reset, then both masters write continuously
        reset_reg = 1;
        step();
        chk("rst2_syxrdata", syx_rdata, 0);
        reset_reg = 0;
        cpu_req = 1; cpu_wr = 1; cpu_addr = 7'h11; cpu_wdata = 8'h01;
        syx_req = 1; syx_wr = 1; syx_addr = 7'h22; syx_wdata = 8'h02; syx_sel = 5'b10000;
        nstb = 0; nca = 0; nsa = 0; last_i = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus_write) begin
                chk("rr_addr", bus_addr, (nstb % 2 == 0) ? 7'h11 : 7'h22);
                chk("rr_owner", bus_owner, nstb % 2);
                if (nstb > 0) chk("rr_gap", i - last_i, 4);
                last_i = i;
                nstb++;
            end
            if (cpu_ack) nca++;
            if (syx_ack) nsa++;
            step();
        end
        cpu_req = 0; syx_req = 0;
        chk("rr_nstb", nstb, 4);
        chk("rr_ncpuack", nca, 2);
        chk("rr_nsyxack", nsa, 2);
        step();

        // SysEx request arrives during a CPU read strobe
        rd_val = 8'h96;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 7'h33; cpu_sel = 5'b00100;
        step();
        step();
        chk("mid_c2_read", bus_read, 1);
        syx_req = 1; syx_wr = 1; syx_addr = 7'h44;
        step();
        chk("mid_c3_owner", bus_owner, 0);
        step();
        chk("mid_c4_ack", cpu_ack, 1);
        chk("mid_c4_rdata", cpu_rdata, 8'h96);
        cpu_req = 0;
        step();
        chk("mid_c5_busy", busy, 0);
        step();
        chk("mid_c6_owner", bus_owner, 1);
        chk("mid_c6_addr", bus_addr, 7'h44);
        step();
        step();
        chk("mid_c8_syxack", syx_ack, 1);
        syx_req = 0;
        step();

        // Reset during WAIT of a CPU read, then retry
        rd_val = 8'h77;
        cpu_req = 1; cpu_wr = 0; cpu_addr = 7'h07;
        step(); step(); step();
        chk("rw_c3_pre", busy, 1);
        reset_reg = 1;
        #1;
        chk("rw_busy", busy, 0);
        chk("rw_sel", bus_sel, 0);
        chk("rw_addr", bus_addr, 0);
        chk("rw_rdata", cpu_rdata, 0);
        step();
        chk("rw_ack", cpu_ack, 0);
        chk("rw_read", bus_read, 0);
        reset_reg = 0;
        step(); step();
        chk("rw2_read", bus_read, 1);
        step(); step();
        chk("rw2_ack", cpu_ack, 1);
        chk("rw2_rdata", cpu_rdata, 8'h77);
        cpu_req = 0;
        step();

        // RD_LAT=1 instance: WAIT skipped
        c1_req = 1; c1_addr = 7'h0A;
        step(); step();
        chk("l1_c2_read", b1_read, 1);
        chk("l1_c2_rdata", c1_rdata, 0);
        step();
        chk("l1_c3_ack", c1_ack, 1);
        chk("l1_c3_rdata", c1_rdata, 8'hC3);
        c1_req = 0;
        step();
        chk("l1_c4_busy", b1_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
